// File: rtl/intersection_scheduler_if.sv
// Bundles the configuration, request and light/status signals of the
// intersection scheduler. The scheduler drives the status side.
interface intersection_scheduler_if #(
  parameter int CNT_W = 11
);
  logic             cfg_load;
  logic [CNT_W-1:0] ns_g_len;
  logic [CNT_W-1:0] ns_y_len;
  logic [CNT_W-1:0] ew_g_len;
  logic [CNT_W-1:0] ew_y_len;
  logic             ns_walk_req;
  logic             ew_walk_req;
  logic             preempt_req;
  logic             preempt_dir;
  logic [1:0]       ns_light;
  logic [1:0]       ew_light;
  logic             ns_walk;
  logic             ew_walk;
  logic [CNT_W-1:0] phase_count;
  logic [2:0]       state;

  modport master (
    output cfg_load, ns_g_len, ns_y_len, ew_g_len, ew_y_len,
    output ns_walk_req, ew_walk_req, preempt_req, preempt_dir,
    input  ns_light, ew_light, ns_walk, ew_walk, phase_count, state
  );

  modport slave (
    input  cfg_load, ns_g_len, ns_y_len, ew_g_len, ew_y_len,
    input  ns_walk_req, ew_walk_req, preempt_req, preempt_dir,
    output ns_light, ew_light, ns_walk, ew_walk, phase_count, state
  );
endinterface

// File: rtl/intersection_scheduler.sv
// Two-approach intersection sequencer: green/yellow/all-red phases with
// shadowed phase lengths, latched pedestrian walk requests and preemption.
module intersection_scheduler #(
  parameter int CNT_W      = 11,
  parameter int DEF_G      = 8,
  parameter int DEF_Y      = 2,
  parameter int ALLRED_LEN = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  intersection_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_LEN - 1);
  localparam logic [CNT_W-1:0] DEF_G_L   = CNT_W'(DEF_G);
  localparam logic [CNT_W-1:0] DEF_Y_L   = CNT_W'(DEF_Y);

  // Zero-length phases are treated as one cycle long.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  function automatic logic [1:0] ns_code(input state_t s);
    case (s)
      NS_GREEN:  return 2'd2;
      NS_YELLOW: return 2'd1;
      default:   return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] ew_code(input state_t s);
    case (s)
      EW_GREEN:  return 2'd2;
      EW_YELLOW: return 2'd1;
      default:   return 2'd0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ns_g_sh_q, ns_y_sh_q, ew_g_sh_q, ew_y_sh_q;
  logic [CNT_W-1:0] ns_y_act_q, ew_g_act_q, ew_y_act_q;
  logic [1:0]       ns_light_q, ew_light_q;
  logic             ns_walk_q, ew_walk_q;
  logic             ns_pend_q, ew_pend_q;
  logic             enter_ns, enter_ew;

  // Preemption toward the own direction freezes the counter; toward the
  // opposite direction it forces the yellow regardless of the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CNT_W'(1);
    case (state_q)
      NS_GREEN: begin
        if (bus.preempt_req && !bus.preempt_dir) begin
          cnt_d = cnt_q;
        end else if (bus.preempt_req || cnt_q == '0) begin
          state_d = NS_YELLOW;
          cnt_d   = len_m1(ns_y_act_q);
        end
      end
      NS_YELLOW: if (cnt_q == '0) begin
        state_d = ALLRED_A;
        cnt_d   = ALLRED_M1;
      end
      ALLRED_A: if (cnt_q == '0) begin
        state_d = EW_GREEN;
        cnt_d   = len_m1(ew_g_act_q);
      end
      EW_GREEN: begin
        if (bus.preempt_req && bus.preempt_dir) begin
          cnt_d = cnt_q;
        end else if (bus.preempt_req || cnt_q == '0) begin
          state_d = EW_YELLOW;
          cnt_d   = len_m1(ew_y_act_q);
        end
      end
      EW_YELLOW: if (cnt_q == '0) begin
        state_d = ALLRED_B;
        cnt_d   = ALLRED_M1;
      end
      // The active copy is taken on this same edge, so NS green reads the shadow.
      ALLRED_B: if (cnt_q == '0) begin
        state_d = NS_GREEN;
        cnt_d   = len_m1(ns_g_sh_q);
      end
      default: begin
        state_d = ALLRED_B;
        cnt_d   = ALLRED_M1;
      end
    endcase
    enter_ns = (state_d == NS_GREEN) && (state_q != NS_GREEN);
    enter_ew = (state_d == EW_GREEN) && (state_q != EW_GREEN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ALLRED_B;
      cnt_q      <= ALLRED_M1;
      ns_light_q <= 2'd0;
      ew_light_q <= 2'd0;
      ns_walk_q  <= 1'b0;
      ew_walk_q  <= 1'b0;
      ns_pend_q  <= 1'b0;
      ew_pend_q  <= 1'b0;
      ns_g_sh_q  <= DEF_G_L;
      ns_y_sh_q  <= DEF_Y_L;
      ew_g_sh_q  <= DEF_G_L;
      ew_y_sh_q  <= DEF_Y_L;
      ns_y_act_q <= DEF_Y_L;
      ew_g_act_q <= DEF_G_L;
      ew_y_act_q <= DEF_Y_L;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ns_light_q <= ns_code(state_d);
      ew_light_q <= ew_code(state_d);
      if (enter_ns) begin
        ns_y_act_q <= ns_y_sh_q;
        ew_g_act_q <= ew_g_sh_q;
        ew_y_act_q <= ew_y_sh_q;
      end
      if (bus.cfg_load) begin
        ns_g_sh_q <= bus.ns_g_len;
        ns_y_sh_q <= bus.ns_y_len;
        ew_g_sh_q <= bus.ew_g_len;
        ew_y_sh_q <= bus.ew_y_len;
      end
      // A request arriving on the entry edge is kept for the following green.
      ns_pend_q <= enter_ns ? bus.ns_walk_req : (ns_pend_q | bus.ns_walk_req);
      ew_pend_q <= enter_ew ? bus.ew_walk_req : (ew_pend_q | bus.ew_walk_req);
      ns_walk_q <= enter_ns ? ns_pend_q : ((state_d == NS_GREEN) && ns_walk_q);
      ew_walk_q <= enter_ew ? ew_pend_q : ((state_d == EW_GREEN) && ew_walk_q);
    end
  end

  assign bus.ns_light    = ns_light_q;
  assign bus.ew_light    = ew_light_q;
  assign bus.ns_walk     = ns_walk_q;
  assign bus.ew_walk     = ew_walk_q;
  assign bus.phase_count = cnt_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: fixed scenarios plus randomized traffic
// compared against a phase/elapsed-time model of the intersection.
module tb_intersection_scheduler;
  localparam int CNT_W  = 11;
  localparam int DEF_G  = 8;
  localparam int DEF_Y  = 2;
  localparam int ALLRED = 2;
  localparam logic [19:0] RST_VEC = {3'd5, 2'd0, 2'd0, 1'b0, 1'b0, 11'd1};

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  intersection_scheduler_if #(.CNT_W(CNT_W)) bus ();

  intersection_scheduler #(
    .CNT_W(CNT_W), .DEF_G(DEF_G), .DEF_Y(DEF_Y), .ALLRED_LEN(ALLRED)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase index 0..5 in spec order, cycles elapsed in that phase.
  int m_ph, m_el;
  int sh[4];
  int act[4];
  bit m_npend, m_epend, m_nwalk, m_ewalk;

  function automatic int clamp1(int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int plen(int ph);
    case (ph)
      0:       return clamp1(act[0]);
      1:       return clamp1(act[1]);
      3:       return clamp1(act[2]);
      4:       return clamp1(act[3]);
      default: return ALLRED;
    endcase
  endfunction

  function automatic logic [19:0] exp_vec();
    logic [1:0] nl, el;
    nl = (m_ph == 0) ? 2'd2 : (m_ph == 1) ? 2'd1 : 2'd0;
    el = (m_ph == 3) ? 2'd2 : (m_ph == 4) ? 2'd1 : 2'd0;
    return {3'(m_ph), nl, el, m_nwalk, m_ewalk, CNT_W'(plen(m_ph) - 1 - m_el)};
  endfunction

  function automatic logic [19:0] obs();
    return {bus.state, bus.ns_light, bus.ew_light, bus.ns_walk, bus.ew_walk, bus.phase_count};
  endfunction

  function automatic logic [3:0] sched(int c);
    int t;
    if (c < 2) return 4'd0;
    t = (c - 2) % 24;
    if (t < 8)  return {2'd2, 2'd0};
    if (t < 10) return {2'd1, 2'd0};
    if (t < 12) return 4'd0;
    if (t < 20) return {2'd0, 2'd2};
    if (t < 22) return {2'd0, 2'd1};
    return 4'd0;
  endfunction

  task automatic model_reset();
    m_ph = 5; m_el = 0;
    sh = '{DEF_G, DEF_Y, DEF_G, DEF_Y};
    act = sh;
    m_npend = 0; m_epend = 0; m_nwalk = 0; m_ewalk = 0;
  endtask

  task automatic model_step();
    int nph;
    nph = m_ph;
    if ((m_ph == 0 || m_ph == 3) && bus.preempt_req) begin
      if (bus.preempt_dir != (m_ph == 3)) begin
        nph = m_ph + 1; m_el = 0;
      end
    end else if (m_el + 1 >= plen(m_ph)) begin
      nph = (m_ph + 1) % 6; m_el = 0;
    end else begin
      m_el++;
    end
    if (nph == 0 && m_ph != 0) begin
      act = sh; m_nwalk = m_npend; m_npend = bus.ns_walk_req;
    end else m_npend = m_npend | bus.ns_walk_req;
    if (nph == 3 && m_ph != 3) begin
      m_ewalk = m_epend; m_epend = bus.ew_walk_req;
    end else m_epend = m_epend | bus.ew_walk_req;
    if (nph != 0) m_nwalk = 0;
    if (nph != 3) m_ewalk = 0;
    if (bus.cfg_load) sh = '{int'(bus.ns_g_len), int'(bus.ns_y_len), int'(bus.ew_g_len), int'(bus.ew_y_len)};
    m_ph = nph;
  endtask

  task automatic clear_inputs();
    bus.cfg_load = 0; bus.ns_g_len = '0; bus.ns_y_len = '0; bus.ew_g_len = '0; bus.ew_y_len = '0;
    bus.ns_walk_req = 0; bus.ew_walk_req = 0; bus.preempt_req = 0; bus.preempt_dir = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (bus.ns_light != 2'd0 && bus.ew_light != 2'd0) begin
        errors++;
        $display("FAIL both_non_red t=%0t ns=%0d ew=%0d required one RED", $time, bus.ns_light, bus.ew_light);
      end
    end
  end

  task automatic test_reset();
    clear_inputs();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (obs() !== RST_VEC) begin
      errors++; $display("FAIL reset_values got=%h exp=%h", obs(), RST_VEC);
    end
    @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      checks++;
      if ({bus.ns_light, bus.ew_light} !== sched(c)) begin
        errors++; $display("FAIL default_schedule cyc=%0d got=%h exp=%h", c, {bus.ns_light, bus.ew_light}, sched(c));
      end
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL default_model cyc=%0d got=%h exp=%h", c, obs(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_cfg_load();
    int rs[$];
    int rl[$];
    int es[13] = '{5, 0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
    int el[13] = '{2, 8, 2, 2, 8, 2, 2, 3, 1, 2, 5, 1, 2};
    int prev, run;
    do_reset();
    bus.ns_g_len = 11'd3; bus.ns_y_len = 11'd1; bus.ew_g_len = 11'd5; bus.ew_y_len = 11'd1;
    prev = int'(bus.state); run = 1;
    for (int c = 0; c < 50; c++) begin
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL cfg_model cyc=%0d got=%h exp=%h", c, obs(), exp_vec());
      end
      bus.cfg_load = (c == 5);
      tick();
      if (int'(bus.state) == prev) run++;
      else begin
        rs.push_back(prev); rl.push_back(run);
        prev = int'(bus.state); run = 1;
      end
    end
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (i >= rs.size()) begin
        errors++; $display("FAIL cfg_run%0d got=none exp=state%0d len%0d", i, es[i], el[i]);
      end else if (rs[i] != es[i] || rl[i] != el[i]) begin
        errors++; $display("FAIL cfg_run%0d got=state%0d len%0d exp=state%0d len%0d", i, rs[i], rl[i], es[i], el[i]);
      end
    end
  endtask

  task automatic test_walk();
    int hi;
    do_reset();
    for (int n = 0; n < 40 && bus.state !== 3'd3; n++) tick();
    bus.ns_walk_req = 1; tick(); bus.ns_walk_req = 0;
    for (int n = 0; n < 40 && bus.state !== 3'd0; n++) tick();
    checks++;
    if (bus.state !== 3'd0) begin
      errors++; $display("FAIL walk_wait_ns_green got=%0d exp=0", bus.state);
    end
    hi = 0;
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL walk_model cyc=%0d got=%h exp=%h", c, obs(), exp_vec());
      end
      if (bus.ns_walk === 1'b1) hi++;
      tick();
    end
    checks++;
    if (hi != 8) begin
      errors++; $display("FAIL walk_len got=%0d exp=8", hi);
    end
    hi = 0;
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL walk_late_model cyc=%0d got=%h exp=%h", c, obs(), exp_vec());
      end
      if (bus.ns_walk === 1'b1) hi++;
      bus.ns_walk_req = (c == 2);
      tick();
    end
    checks++;
    if (hi != 0) begin
      errors++; $display("FAIL walk_late_same_phase got=%0d exp=0", hi);
    end
    hi = 0;
    for (int c = 0; c < 24; c++) begin
      if (bus.ns_walk === 1'b1) hi++;
      tick();
    end
    checks++;
    if (hi != 8) begin
      errors++; $display("FAIL walk_late_next_phase got=%0d exp=8", hi);
    end
  endtask

  task automatic test_preempt();
    int xs[5] = '{1, 1, 2, 2, 3};
    int xc[5] = '{1, 0, 1, 0, 7};
    int s, k;
    do_reset();
    for (int n = 0; n < 4; n++) tick();
    checks++;
    if (bus.state !== 3'd0) begin
      errors++; $display("FAIL preempt_start got=%0d exp=0", bus.state);
    end
    bus.preempt_req = 1; bus.preempt_dir = 1;
    for (int i = 0; i < 25; i++) begin
      tick();
      s = (i < 5) ? xs[i] : 3;
      k = (i < 5) ? xc[i] : 7;
      checks++;
      if (bus.state !== 3'(s) || bus.phase_count !== CNT_W'(k)) begin
        errors++; $display("FAIL preempt_seq i=%0d got=%0d/%0d exp=%0d/%0d", i, bus.state, bus.phase_count, s, k);
      end
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL preempt_model i=%0d got=%h exp=%h", i, obs(), exp_vec());
      end
    end
    bus.preempt_req = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.state !== 3'd3 || bus.phase_count !== CNT_W'(6 - i)) begin
        errors++; $display("FAIL preempt_release i=%0d got=%0d/%0d exp=3/%0d", i, bus.state, bus.phase_count, 6 - i);
      end
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    bus.cfg_load = 1; tick(); bus.cfg_load = 0;
    for (int c = 0; c < 30; c++) begin
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL zero_model cyc=%0d got=%h exp=%h", c, obs(), exp_vec());
      end
      checks++;
      if (bus.phase_count > ((bus.state == 3'd2 || bus.state == 3'd5) ? 11'd1 : 11'd0)) begin
        errors++; $display("FAIL zero_count cyc=%0d state=%0d got=%0d", c, bus.state, bus.phase_count);
      end
      tick();
    end
    for (int n = 0; n < 10 && bus.state !== 3'd3; n++) tick();
    checks++;
    if (bus.state !== 3'd3) begin
      errors++; $display("FAIL zero_wait_ew_green got=%0d exp=3", bus.state);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs() !== RST_VEC) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", obs(), RST_VEC);
    end
    @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL random_model cyc=%0d got=%h exp=%h", c, obs(), exp_vec());
      end
      bus.ns_walk_req = ($urandom_range(0, 15) == 0);
      bus.ew_walk_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0) begin
        bus.preempt_req = ~bus.preempt_req;
        bus.preempt_dir = 1'($urandom_range(0, 1));
      end
      bus.cfg_load = ($urandom_range(0, 29) == 0);
      if (bus.cfg_load) begin
        bus.ns_g_len = CNT_W'($urandom_range(0, 6));
        bus.ns_y_len = CNT_W'($urandom_range(0, 6));
        bus.ew_g_len = CNT_W'($urandom_range(0, 6));
        bus.ew_y_len = CNT_W'($urandom_range(0, 6));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_cfg_load();
    test_walk();
    test_preempt();
    test_zero_len();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/intersection_scheduler.md
Name: intersection_scheduler

Overview:
Sequences a two-approach intersection: north-south (NS) and east-west (EW). It drives one light-state code per approach using the codebase encoding 0=RED, 1=YELLOW, 2=GREEN. It also adds all-red clearance, latched pedestrian walk requests, and emergency preemption. It sits above the per-approach traffic light datapath and provides its phase lengths through a shadowed configuration port.

Parameters:
CNT_W, 11, width of length inputs and phase counter
DEF_G, 8, green length (cycles) used from reset until first cfg_load takes effect
DEF_Y, 2, yellow length (cycles) used from reset until first cfg_load takes effect
ALLRED_LEN, 2, all-red clearance length (cycles); must be >=1

Ports:
clock  in  1  sole clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
cfg_load  in  1  one-cycle strobe: capture the four lengths into shadow registers
ns_g_len  in  CNT_W  NS green length, cycles
ns_y_len  in  CNT_W  NS yellow length, cycles
ew_g_len  in  CNT_W  EW green length, cycles
ew_y_len  in  CNT_W  EW yellow length, cycles
ns_walk_req  in  1  pedestrian button, NS crossing (pulse or level)
ew_walk_req  in  1  pedestrian button, EW crossing
preempt_req  in  1  emergency preemption request, level
preempt_dir  in  1  0=NS, 1=EW; direction to be given green
ns_light  out  2  NS light code
ew_light  out  2  EW light code
ns_walk  out  1  NS walk lamp
ew_walk  out  1  EW walk lamp
phase_count  out  CNT_W  remaining cycles in current phase minus one
state  out  3  FSM state code (debug)

Behaviour:
- FSM states and codes:
  - NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5
  - Codes 6 and 7 are unreachable and recover to ALLRED_B with count=ALLRED_LEN-1.
  - Normal order: NS_GREEN > NS_YELLOW > ALLRED_A > EW_GREEN > EW_YELLOW > ALLRED_B > NS_GREEN.
- Light outputs:
  - NS_GREEN: ns_light=2, ew_light=0. NS_YELLOW: ns_light=1, ew_light=0.
  - EW phases mirror this. ALLRED_*: both 0.
  - Both lights are never non-RED in the same cycle. This is an invariant.
- Reset (async):
  - state=ALLRED_B, phase_count=ALLRED_LEN-1, both lights 0, both walk 0.
  - Walk-pending flags cleared; shadow and active lengths set to DEF_G/DEF_Y.
  - After reset release, the first NS_GREEN starts ALLRED_LEN cycles later.
- Phase timing:
  - On phase entry, phase_count loads L-1, where L is the phase length.
  - It decrements by 1 each cycle. At phase_count==0 the next edge enters the next phase.
  - A phase with length L therefore lasts exactly L cycles.
  - A length input of 0 is clamped to 1. There is no wrap-around.
- Configuration:
  - cfg_load captures the four lengths into shadow registers in that cycle.
  - Shadow is copied to active on the edge entering NS_GREEN (cycle start), so a cycle in progress is never altered.
  - If cfg_load coincides with the NS_GREEN entry edge, entry uses the old shadow; the new values apply at the next cycle start.
- Walk:
  - ns_walk_req high sets ns_walk_pend; ew_walk_req sets ew_walk_pend likewise.
  - On entry to NS_GREEN with ns_walk_pend=1: ns_walk=1 for the whole green, and the pend flag clears on the entry edge.
  - ns_walk=0 in all other states.
  - A request during NS_GREEN (including the entry cycle) stays pending for the next NS_GREEN.
  - EW behaves symmetrically.
- Preemption, evaluated each cycle in GREEN states only:
  - X_GREEN with preempt_req=1 for the opposite direction: next edge enters X_YELLOW with full yellow length. X walk drops with the green.
  - X_GREEN with preempt_req=1 for X: phase_count holds, extending the green until preempt_req falls.
  - Yellow and all-red phases are never shortened or extended, so the requested direction reaches green through normal clearance.
  - preempt_req has priority over phase_count expiry (hold wins).
- reset asserted mid-phase returns immediately to the reset state; pending walks are lost.

Test Plan:
- Reset, defaults (G=8, Y=2, ALLRED=2):
  - NS green for cycles 2-9, yellow 10-11, all-red 12-13.
  - EW green 14-21, EW yellow 22-23, all-red 24-25; period 24 cycles.
  - ns_light/ew_light never both non-zero.
- cfg_load with ns_g_len=3, ew_g_len=5, ns_y_len=ew_y_len=1, pulsed mid-NS_GREEN:
  - The current cycle is unchanged.
  - The next cycle has NS green 3, yellow 1, EW green 5, yellow 1.
- ns_walk_req pulsed during EW_GREEN: ns_walk=1 for exactly the 8 cycles of the next NS_GREEN, then 0.
- ns_walk_req pulsed during NS_GREEN: no effect this phase; ns_walk=1 for the entire following NS_GREEN.
- preempt_req=1, preempt_dir=1 at cycle 3 of NS_GREEN:
  - NS_YELLOW next cycle for 2 cycles, then ALLRED_A for 2, then EW_GREEN.
  - Holding preempt keeps EW_GREEN indefinitely with phase_count frozen.
  - Releasing it resumes countdown.
- Zero lengths (all four = 0) loaded: each green and yellow lasts 1 cycle; the counter never wraps. Reset asserted mid-EW_GREEN puts outputs at reset values in the same cycle.
